// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler that shares one UART byte transmitter between
//   NUM_SRC producers. Each source has a change filter: a byte equal to the
//   last byte sent for that source is acknowledged and dropped, and the drop
//   is counted. The LED bank shows the last data byte handed to the UART.
//
//   Optional feature macro: TX_HDR_EN
//     defined   : every forwarded byte is preceded by a header byte
//                 {HDR_TAG, source id}
//     undefined : one UART byte per event, header states not built
//
// Ports
//   uart_clk   in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   src_valid  in   [NUM_SRC]   per-source request, held until src_ack
//   src_data   in   [8*NUM_SRC] per-source byte, [8i+7:8i] = source i
//   src_ack    out  [NUM_SRC]   one-hot pulse: request consumed (sent/dropped)
//   tx_busy    in   UART busy, rises within one cycle of tx_start
//   tx_start   out  one-cycle pulse, UART loads tx_data
//   tx_data    out  [8] byte to UART, holds outside start cycles
//   leds       out  [8] last data byte handed to UART
//   drop_cnt   out  [CNT_W] saturating count of dropped (unchanged) bytes

module uart_tx_sched #(
  parameter int         NUM_SRC = 4,
  parameter int         CNT_W   = 16,
  parameter logic [3:0] HDR_TAG = 4'hA
) (
  input  logic                 uart_clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  output logic [NUM_SRC-1:0]   src_ack,
  input  logic                 tx_busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic [7:0]           leds,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_START_D = 3'd2,
    ST_GAP_D   = 3'd3,
    ST_WAIT_D  = 3'd4
`ifdef TX_HDR_EN
    ,
    ST_START_H = 3'd5,
    ST_GAP_H   = 3'd6,
    ST_WAIT_H  = 3'd7
`endif
  } state_t;

  state_t             state_r;
  state_t             state_next_s;

  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   gid_r;
  logic [7:0]         cap_r;
  logic [7:0]         last_r [NUM_SRC];
  logic [NUM_SRC-1:0] seen_r;
  logic [7:0]         tx_data_r;
  logic [7:0]         leds_r;
  logic [CNT_W-1:0]   drop_cnt_r;

  logic               grant_found_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [IDX_W-1:0]   rr_ptr_next_s;
  logic [IDX_W:0]     cand_s;
  logic               drop_s;
  logic [NUM_SRC-1:0] src_ack_s;
  logic               tx_start_s;

  // First valid source at or after rr_ptr, wrapping past NUM_SRC-1 to 0.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand_s = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
      if (cand_s >= (IDX_W+1)'(NUM_SRC)) begin
        cand_s = cand_s - (IDX_W+1)'(NUM_SRC);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && src_valid[cand_s[IDX_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[IDX_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Pointer moves one past the granted source so it gets lowest priority next.
  always_comb begin
    if (grant_idx_s == IDX_W'(NUM_SRC - 1)) begin
      rr_ptr_next_s = '0;
    end else begin
      rr_ptr_next_s = grant_idx_s + IDX_W'(1);
    end
  end

  // A byte is dropped only once the source has sent something since reset.
  always_comb begin
    drop_s = seen_r[gid_r] && (cap_r == last_r[gid_r]);
  end

  // FSM state register.
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; GAP states give the UART one cycle to raise tx_busy.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|src_valid) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (drop_s) begin
          state_next_s = ST_IDLE;
        end else begin
`ifdef TX_HDR_EN
          state_next_s = ST_START_H;
`else
          state_next_s = ST_START_D;
`endif
        end
      end
`ifdef TX_HDR_EN
      ST_START_H: state_next_s = ST_GAP_H;
      ST_GAP_H:   state_next_s = ST_WAIT_H;
      ST_WAIT_H: begin
        if (tx_busy) begin
          state_next_s = ST_WAIT_H;
        end else begin
          state_next_s = ST_START_D;
        end
      end
`endif
      ST_START_D: state_next_s = ST_GAP_D;
      ST_GAP_D:   state_next_s = ST_WAIT_D;
      ST_WAIT_D: begin
        if (tx_busy) begin
          state_next_s = ST_WAIT_D;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: ack only in CHECK, start pulses only in START states.
  always_comb begin
    src_ack_s  = '0;
    tx_start_s = 1'b0;
    case (state_r)
      ST_CHECK:   src_ack_s  = {{(NUM_SRC-1){1'b0}}, 1'b1} << gid_r;
      ST_START_D: tx_start_s = 1'b1;
`ifdef TX_HDR_EN
      ST_START_H: tx_start_s = 1'b1;
`endif
      default: begin
        src_ack_s  = '0;
        tx_start_s = 1'b0;
      end
    endcase
  end

  // Datapath: capture on grant, filter bookkeeping, UART byte and LED registers.
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r   <= '0;
      gid_r      <= '0;
      cap_r      <= 8'h00;
      seen_r     <= '0;
      tx_data_r  <= 8'h00;
      leds_r     <= 8'h00;
      drop_cnt_r <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        last_r[i] <= 8'h00;
      end
    end else begin
      if (state_r == ST_IDLE && grant_found_s) begin
        cap_r    <= src_data[{grant_idx_s, 3'b000} +: 8];
        gid_r    <= grant_idx_s;
        rr_ptr_r <= rr_ptr_next_s;
      end

      if (state_r == ST_CHECK && drop_s && drop_cnt_r != {CNT_W{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end

      // tx_data is loaded one edge early so it is valid during the start pulse.
      if (state_next_s == ST_START_D) begin
        tx_data_r <= cap_r;
      end
`ifdef TX_HDR_EN
      else if (state_next_s == ST_START_H) begin
        tx_data_r <= {HDR_TAG, 4'(gid_r)};
      end
`endif

      if (state_r == ST_START_D) begin
        last_r[gid_r] <= cap_r;
        seen_r[gid_r] <= 1'b1;
        leds_r        <= cap_r;
      end
    end
  end

  assign src_ack  = src_ack_s;
  assign tx_start = tx_start_s;
  assign tx_data  = tx_data_r;
  assign leds     = leds_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: randomized request batches scored against a
// behavioural round-robin / change-filter model, plus directed reset and
// drop-counter saturation scenarios (CNT_W=4 build).
module tb_uart_tx_sched;

  localparam int N      = 4;
  localparam int CW     = 4;
  localparam int MAXCNT = 15;

  logic           uart_clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   src_valid = '0;
  logic [8*N-1:0] src_data = '0;
  logic [N-1:0]   src_ack;
  logic           tx_busy = 1'b0;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic [7:0]     leds;
  logic [CW-1:0]  drop_cnt;

  uart_tx_sched #(.NUM_SRC(N), .CNT_W(CW), .HDR_TAG(4'hA)) dut (
    .uart_clk (uart_clk),
    .rst      (rst),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ack  (src_ack),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .leds     (leds),
    .drop_cnt (drop_cnt)
  );

  always #5 uart_clk = ~uart_clk;

  typedef struct {
    bit         is_tx;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // reference model state
  int         m_ptr;
  logic [7:0] m_last [N];
  bit         m_seen [N];
  int         m_drop;
  logic [7:0] m_leds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_drop = 0;
    m_leds = 8'h00;
    for (int i = 0; i < N; i++) begin
      m_last[i] = 8'h00;
      m_seen[i] = 1'b0;
    end
  endtask

  // Sources in the batch are served in circular order starting at the pointer.
  task automatic model_issue(input logic [N-1:0] mask, input logic [8*N-1:0] data);
    int last_g;
    logic [7:0] b;
    last_g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (mask[idx]) begin
        b = data[8*idx +: 8];
        exp_q.push_back('{1'b0, 8'(1 << idx)});
        if (m_seen[idx] && m_last[idx] == b) begin
          if (m_drop < MAXCNT) m_drop++;
        end else begin
`ifdef TX_HDR_EN
          exp_q.push_back('{1'b1, {4'hA, 4'(idx)}});
`endif
          exp_q.push_back('{1'b1, b});
          m_last[idx] = b;
          m_seen[idx] = 1'b1;
          m_leds      = b;
        end
        last_g = idx;
      end
    end
    if (last_g >= 0) m_ptr = (last_g + 1) % N;
  endtask

  always @(posedge uart_clk) cyc <= cyc + 1;

  // UART busy model: busy rises one cycle after each start, lasts 3..10 cycles
  initial begin
    int len;
    forever begin
      @(negedge uart_clk);
      if (tx_start === 1'b1 && !rst) begin
        len = $urandom_range(3, 10);
        @(posedge uart_clk);
        #1 tx_busy = 1'b1;
        repeat (len) @(posedge uart_clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Monitor: pop expected output whenever the DUT acks or starts a byte
  initial begin
    int  ack_cyc;
    bit  first_after_ack;
    exp_t e;
    logic [8:0] act;
    ack_cyc = 0;
    first_after_ack = 1'b0;
    forever begin
      @(negedge uart_clk);
      if (!rst) begin
        if (tx_start === 1'b1 && tx_busy === 1'b1) check("start_while_busy", 32'd1, 32'd0);
        if (src_ack !== '0 || tx_start !== 1'b0) begin
          act = tx_start ? {1'b1, tx_data} : {1'b0, 8'(src_ack)};
          if (src_ack !== '0 && tx_start !== 1'b0) check("ack_and_start", 32'd1, 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(act), 32'h0);
          end else begin
            e = exp_q.pop_front();
            check(e.is_tx ? "tx_data" : "src_ack", 32'(act), 32'({e.is_tx, e.val}));
          end
          if (src_ack !== '0) begin
            ack_cyc = cyc;
            first_after_ack = 1'b1;
          end else if (first_after_ack) begin
            check("ack_to_start_latency", 32'(cyc - ack_cyc), 32'd1);
            first_after_ack = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_done();
    int c;
    c = 0;
    while (src_valid != '0 && c < 400) begin
      @(negedge uart_clk);
      src_valid = src_valid & ~src_ack;
      c++;
    end
    if (src_valid != '0) begin
      check("ack_timeout", 32'(src_valid), 32'd0);
      src_valid = '0;
    end
    c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(negedge uart_clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      check("output_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run_batch(input logic [N-1:0] mask, input logic [8*N-1:0] data);
    @(negedge uart_clk);
    model_issue(mask, data);
    src_data  = data;
    src_valid = mask;
    wait_done();
    repeat (3) @(negedge uart_clk);
    check("leds", 32'(leds), 32'(m_leds));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*N-1:0] d;
    logic [N-1:0]   m;
    model_reset();
    #2 rst = 1'b1;
    repeat (3) @(negedge uart_clk);
    check("rst_src_ack", 32'(src_ack), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // first send, repeat drop, changed byte sent
    run_batch(4'b0001, {24'h0, 8'h3C});
    run_batch(4'b0001, {24'h0, 8'h3C});
    run_batch(4'b0001, {24'h0, 8'h3D});
    // all four valid, distinct bytes
    run_batch(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
    // lone source 2 twice: second time the pointer sits at 3 and must wrap
    run_batch(4'b0100, {8'h44, 8'h5A, 8'h22, 8'h11});
    run_batch(4'b0100, {8'h44, 8'h5B, 8'h22, 8'h11});
    // zero byte is sent when first for its source... already seen here, so new src uses 0x00 path below
    // randomized batches biased toward repeats
    for (int r = 0; r < 40; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        if (m_seen[i] && $urandom_range(0, 2) == 0) d[8*i +: 8] = m_last[i];
        else d[8*i +: 8] = 8'($urandom);
      end
      run_batch(m, d);
    end
    // drive drop counter into saturation
    run_batch(4'b0010, {16'h0, 8'h77, 8'h0});
    for (int r = 0; r < 20; r++) run_batch(4'b0010, {16'h0, 8'h77, 8'h0});

    // reset while waiting on a busy UART after a data byte
    @(negedge uart_clk);
    model_issue(4'b0001, {24'h0, 8'h55});
    src_data  = {24'h0, 8'h55};
    src_valid = 4'b0001;
    wait_done();
    @(posedge uart_clk);
    @(posedge uart_clk);
    #2 rst = 1'b1;
    #1;
    check("arst_src_ack", 32'(src_ack), 32'd0);
    check("arst_tx_start", 32'(tx_start), 32'd0);
    check("arst_tx_data", 32'(tx_data), 32'd0);
    check("arst_leds", 32'(leds), 32'd0);
    check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    model_reset();
    for (int c = 0; c < 40 && tx_busy; c++) @(negedge uart_clk);
    @(negedge uart_clk);
    rst = 1'b0;
    // seen cleared: previously sent bytes go out again, including 0x00 on a fresh source
    run_batch(4'b0001, {24'h0, 8'h3C});
    run_batch(4'b1000, {8'h00, 24'h0});
    run_batch(4'b1000, {8'h00, 24'h0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
